imem_port_ctrl: RTL and testbench

//  Owns the single instruction-RAM port and shares it between two requesters:
//  the UART software upgrader (write-only, no backpressure) and the CPU core (req/gnt).

---
 rtl/imem_port_ctrl.sv | 159 +++++++++++++++
 tb/tb_imem_port_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_ctrl.sv
// Instruction-RAM port owner: arbitrates between the UART upgrader and the CPU core,
// and sequences boot, upgrade session, idle-timeout end of upload and core release.
module imem_port_ctrl #(
  parameter int unsigned ADDR_LEN       = 14,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RST_HOLD       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  during_sw_upgrade,
  input  logic                  upg_wr_en,
  input  logic [ADDR_LEN-1:0]   upg_addr,
  input  logic [XLEN-1:0]       upg_wr_data,
  input  logic [XLEN/8-1:0]     upg_we,
  input  logic                  core_req,
  input  logic [ADDR_LEN-1:0]   core_addr,
  input  logic [XLEN-1:0]       core_wr_data,
  input  logic [XLEN/8-1:0]     core_we,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [XLEN-1:0]       core_rdata,
  output logic                  ram_en,
  output logic [ADDR_LEN-1:0]   ram_addr,
  output logic [XLEN-1:0]       ram_wr_data,
  output logic [XLEN/8-1:0]     ram_we,
  input  logic [XLEN-1:0]       ram_rdata,
  output logic                  core_rstb,
  output logic                  upgrade_done,
  output logic [ADDR_LEN:0]     upg_word_cnt,
  output logic                  upg_drop
);

  localparam int unsigned BeW   = XLEN / 8;
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StBoot, StUpgrade, StHold, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic [ADDR_LEN:0]  cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic               rvalid_q, rvalid_d;
  logic               trig;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idle_d      = idle_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    drop_d      = drop_q;
    req_d       = during_sw_upgrade;
    trig        = during_sw_upgrade & ~req_q;
    core_gnt    = 1'b0;
    core_rstb   = 1'b0;
    ram_en      = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_we      = '0;

    if (upg_wr_en && (state_q != StUpgrade)) drop_d = 1'b1;

    unique case (state_q)
      StBoot: begin
        hold_d = hold_q + 1'b1;
        if (trig) begin
          state_d = StUpgrade;
        end else if (hold_q == HoldW'(RST_HOLD - 1)) begin
          state_d = StRun;
        end
      end
      StUpgrade: begin
        ram_en      = upg_wr_en;
        ram_addr    = upg_addr;
        ram_wr_data = upg_wr_data;
        ram_we      = upg_we;
        // A write always wins over a coincident timeout.
        if (upg_wr_en) begin
          idle_d = '0;
          if (upg_we[BeW-1] && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end else if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
          if (cnt_q != '0) begin
            state_d = StHold;
            hold_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldW'(RST_HOLD - 1)) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        core_rstb = 1'b1;
        core_gnt  = core_req;
        if (core_req) begin
          ram_en      = 1'b1;
          ram_addr    = core_addr;
          ram_wr_data = core_wr_data;
          ram_we      = core_we;
        end
        if (trig) state_d = StDrain;
      end
      StDrain: begin
        // A read granted in the trigger cycle returns during this single cycle.
        core_rstb = 1'b1;
        state_d   = StUpgrade;
      end
      default: state_d = StBoot;
    endcase

    if ((state_d == StUpgrade) && (state_q != StUpgrade)) begin
      cnt_d  = '0;
      idle_d = '0;
      done_d = 1'b0;
    end

    rvalid_d = core_gnt & ~(|core_we);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= StBoot;
      req_q    <= 1'b0;
      hold_q   <= '0;
      idle_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign core_rvalid  = rvalid_q;
  assign core_rdata   = ram_rdata;
  assign upgrade_done = done_q;
  assign upg_word_cnt = cnt_q;
  assign upg_drop     = drop_q;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Directed bench for imem_port_ctrl with RST_HOLD=4, TIMEOUT_CYCLES=8 and a simple RAM model.
module tb_imem_port_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        dsu;
  logic        upg_wr_en;
  logic [13:0] upg_addr;
  logic [31:0] upg_wr_data;
  logic [3:0]  upg_we;
  logic        core_req;
  logic [13:0] core_addr;
  logic [31:0] core_wr_data;
  logic [3:0]  core_we;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        ram_en;
  logic [13:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata = '0;
  logic        core_rstb;
  logic        upgrade_done;
  logic [14:0] upg_word_cnt;
  logic        upg_drop;

  int n_vec = 0;
  int n_bad = 0;
  int wr_count = 0;

  imem_port_ctrl #(
    .ADDR_LEN       (14),
    .XLEN           (32),
    .RST_HOLD       (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .rstb              (rstb),
    .during_sw_upgrade (dsu),
    .upg_wr_en         (upg_wr_en),
    .upg_addr          (upg_addr),
    .upg_wr_data       (upg_wr_data),
    .upg_we            (upg_we),
    .core_req          (core_req),
    .core_addr         (core_addr),
    .core_wr_data      (core_wr_data),
    .core_we           (core_we),
    .core_gnt          (core_gnt),
    .core_rvalid       (core_rvalid),
    .core_rdata        (core_rdata),
    .ram_en            (ram_en),
    .ram_addr          (ram_addr),
    .ram_wr_data       (ram_wr_data),
    .ram_we            (ram_we),
    .ram_rdata         (ram_rdata),
    .core_rstb         (core_rstb),
    .upgrade_done      (upgrade_done),
    .upg_word_cnt      (upg_word_cnt),
    .upg_drop          (upg_drop)
  );

  always #5 clk = ~clk;

  // RAM model: read data is a fixed function of the address, one cycle after the access.
  always @(posedge clk) begin
    if (ram_en && ram_we == 4'h0) ram_rdata <= 32'hCAFE0000 ^ {18'h0, ram_addr};
    if (ram_en && ram_we != 4'h0) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    dsu = 1'b0; upg_wr_en = 1'b0; upg_addr = '0; upg_wr_data = '0; upg_we = '0;
    core_req = 1'b1; core_addr = 14'h10; core_wr_data = '0; core_we = '0;
    do_reset();
    rstb = 1'b0;
    if (core_rstb !== 1'b0) begin n_bad++; $display("FAIL rst_core_rstb: got %b want 0", core_rstb); end
    n_vec++;
    if (core_gnt !== 1'b0 || ram_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_access: gnt=%b ram_en=%b want 0 0", core_gnt, ram_en);
    end
    n_vec++;
    if (upgrade_done !== 1'b0 || upg_word_cnt !== 15'd0 || upg_drop !== 1'b0 || core_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_status: done=%b cnt=%0d drop=%b rvalid=%b want 0 0 0 0",
               upgrade_done, upg_word_cnt, upg_drop, core_rvalid);
    end
    n_vec++;
    rstb = 1'b1;
    core_req = 1'b0;
    repeat (3) tick();
    if (core_rstb !== 1'b0) begin n_bad++; $display("FAIL boot_hold3: got %b want 0", core_rstb); end
    n_vec++;
    tick();
    if (core_rstb !== 1'b1) begin n_bad++; $display("FAIL boot_release: got %b want 1", core_rstb); end
    n_vec++;
    core_req = 1'b1; core_addr = 14'h10; core_we = 4'h0;
    #1;
    if (core_gnt !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 14'h10 || ram_we !== 4'h0) begin
      n_bad++;
      $display("FAIL read_gnt: gnt=%b en=%b addr=%h we=%h want 1 1 0010 0",
               core_gnt, ram_en, ram_addr, ram_we);
    end
    n_vec++;
    tick();
    core_req = 1'b0;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hCAFE0010) begin
      n_bad++; $display("FAIL read_data: rvalid=%b rdata=%h want 1 cafe0010", core_rvalid, core_rdata);
    end
    n_vec++;
    tick();
    if (core_rvalid !== 1'b0) begin n_bad++; $display("FAIL read_once: got %b want 0", core_rvalid); end
    n_vec++;
  endtask

  task automatic test_upgrade();
    int base;
    logic [3:0]  exp_we;
    logic [13:0] exp_addr;
    dsu = 1'b1;
    do_reset();
    tick();
    if (core_rstb !== 1'b0 || upg_word_cnt !== 15'd0) begin
      n_bad++; $display("FAIL upg_entry: rstb=%b cnt=%0d want 0 0", core_rstb, upg_word_cnt);
    end
    n_vec++;
    base = wr_count;
    for (int i = 0; i < 8; i++) begin
      upg_wr_en = 1'b1;
      exp_addr = (i < 4) ? 14'd0 : 14'd1;
      exp_we = 4'(1 << (i % 4));
      upg_addr = exp_addr; upg_we = exp_we; upg_wr_data = 32'h1000 + 32'(i);
      #1;
      if (ram_en !== 1'b1 || ram_we !== exp_we || ram_addr !== exp_addr || ram_wr_data !== 32'h1000 + 32'(i)) begin
        n_bad++;
        $display("FAIL upg_fwd[%0d]: en=%b we=%h addr=%h data=%h want 1 %h %h %h", i, ram_en, ram_we,
                 ram_addr, ram_wr_data, exp_we, exp_addr, 32'h1000 + 32'(i));
      end
      n_vec++;
      tick();
    end
    upg_wr_en = 1'b0;
    if (wr_count - base !== 8) begin n_bad++; $display("FAIL upg_writes: got %0d want 8", wr_count - base); end
    n_vec++;
    if (upg_word_cnt !== 15'd2) begin n_bad++; $display("FAIL upg_cnt: got %0d want 2", upg_word_cnt); end
    n_vec++;
    repeat (7) tick();
    if (upgrade_done !== 1'b0 || ram_en !== 1'b0) begin
      n_bad++; $display("FAIL upg_idle7: done=%b en=%b want 0 0", upgrade_done, ram_en);
    end
    n_vec++;
    tick();
    if (upgrade_done !== 1'b1 || core_rstb !== 1'b0) begin
      n_bad++; $display("FAIL upg_timeout: done=%b rstb=%b want 1 0", upgrade_done, core_rstb);
    end
    n_vec++;
    repeat (3) tick();
    if (core_rstb !== 1'b0) begin n_bad++; $display("FAIL hold3: got %b want 0", core_rstb); end
    n_vec++;
    tick();
    if (core_rstb !== 1'b1 || upgrade_done !== 1'b1) begin
      n_bad++; $display("FAIL hold_release: rstb=%b done=%b want 1 1", core_rstb, upgrade_done);
    end
    n_vec++;
    dsu = 1'b0;
    tick();
  endtask

  task automatic test_no_timeout();
    dsu = 1'b1;
    tick();
    tick();
    if (core_rstb !== 1'b0 || upgrade_done !== 1'b0 || upg_word_cnt !== 15'd0) begin
      n_bad++;
      $display("FAIL reentry: rstb=%b done=%b cnt=%0d want 0 0 0", core_rstb, upgrade_done, upg_word_cnt);
    end
    n_vec++;
    repeat (100) tick();
    if (core_rstb !== 1'b0 || upgrade_done !== 1'b0) begin
      n_bad++; $display("FAIL idle100: rstb=%b done=%b want 0 0", core_rstb, upgrade_done);
    end
    n_vec++;
    upg_wr_en = 1'b1; upg_we = 4'h8; upg_addr = 14'd7;
    tick();
    upg_wr_en = 1'b0;
    repeat (7) tick();
    upg_wr_en = 1'b1; upg_we = 4'h4;
    #1;
    if (ram_en !== 1'b1) begin n_bad++; $display("FAIL coincident_fwd: en=%b want 1", ram_en); end
    n_vec++;
    tick();
    upg_wr_en = 1'b0;
    repeat (7) tick();
    if (upgrade_done !== 1'b0) begin n_bad++; $display("FAIL coincident_stay: done=%b want 0", upgrade_done); end
    n_vec++;
    tick();
    if (upgrade_done !== 1'b1 || upg_word_cnt !== 15'd1) begin
      n_bad++; $display("FAIL coincident_end: done=%b cnt=%0d want 1 1", upgrade_done, upg_word_cnt);
    end
    n_vec++;
    repeat (4) tick();
    if (core_rstb !== 1'b1) begin n_bad++; $display("FAIL run_again: got %b want 1", core_rstb); end
    n_vec++;
    dsu = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    core_req = 1'b1; core_addr = 14'h22; core_we = 4'h0; dsu = 1'b1;
    #1;
    if (core_gnt !== 1'b1 || ram_en !== 1'b1) begin
      n_bad++; $display("FAIL drain_gnt: gnt=%b en=%b want 1 1", core_gnt, ram_en);
    end
    n_vec++;
    tick();
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hCAFE0022 || core_gnt !== 1'b0 || ram_en !== 1'b0
        || core_rstb !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_cycle: rvalid=%b rdata=%h gnt=%b en=%b rstb=%b want 1 cafe0022 0 0 1",
               core_rvalid, core_rdata, core_gnt, ram_en, core_rstb);
    end
    n_vec++;
    tick();
    if (core_rstb !== 1'b0 || core_gnt !== 1'b0 || ram_en !== 1'b0 || core_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_upg: rstb=%b gnt=%b en=%b rvalid=%b want 0 0 0 0",
               core_rstb, core_gnt, ram_en, core_rvalid);
    end
    n_vec++;
    core_req = 1'b0;
    dsu = 1'b0;
  endtask

  task automatic test_drop();
    int base;
    do_reset();
    repeat (4) tick();
    if (core_rstb !== 1'b1 || upg_drop !== 1'b0) begin
      n_bad++; $display("FAIL drop_pre: rstb=%b drop=%b want 1 0", core_rstb, upg_drop);
    end
    n_vec++;
    base = wr_count;
    upg_wr_en = 1'b1; upg_we = 4'hF; upg_addr = 14'd5;
    #1;
    if (ram_en !== 1'b0) begin n_bad++; $display("FAIL drop_nofwd: en=%b want 0", ram_en); end
    n_vec++;
    tick();
    upg_wr_en = 1'b0;
    if (upg_drop !== 1'b1) begin n_bad++; $display("FAIL drop_set: got %b want 1", upg_drop); end
    n_vec++;
    repeat (5) tick();
    if (upg_drop !== 1'b1 || wr_count !== base) begin
      n_bad++; $display("FAIL drop_sticky: drop=%b writes=%0d want 1 0", upg_drop, wr_count - base);
    end
    n_vec++;
  endtask

  task automatic test_mid_reset();
    dsu = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      upg_wr_en = 1'b1; upg_we = 4'h8; upg_addr = 14'(i);
      tick();
    end
    upg_wr_en = 1'b0;
    if (upg_word_cnt !== 15'd3) begin n_bad++; $display("FAIL mid_cnt3: got %0d want 3", upg_word_cnt); end
    n_vec++;
    rstb = 1'b0;
    tick();
    if (core_rstb !== 1'b0 || upgrade_done !== 1'b0 || upg_word_cnt !== 15'd0 || upg_drop !== 1'b0
        || ram_en !== 1'b0 || core_rvalid !== 1'b0 || core_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: rstb=%b done=%b cnt=%0d drop=%b en=%b rvalid=%b gnt=%b want all 0",
               core_rstb, upgrade_done, upg_word_cnt, upg_drop, ram_en, core_rvalid, core_gnt);
    end
    n_vec++;
    rstb = 1'b1;
    tick();
    upg_wr_en = 1'b1; upg_we = 4'h8; upg_addr = 14'd9;
    #1;
    if (core_rstb !== 1'b0 || ram_en !== 1'b1) begin
      n_bad++; $display("FAIL restart_fwd: rstb=%b en=%b want 0 1", core_rstb, ram_en);
    end
    n_vec++;
    tick();
    upg_wr_en = 1'b0;
    if (upg_word_cnt !== 15'd1) begin n_bad++; $display("FAIL restart_cnt: got %0d want 1", upg_word_cnt); end
    n_vec++;
  endtask

  initial begin
    rstb = 1'b0;
    test_reset();
    test_upgrade();
    test_no_timeout();
    test_drain();
    test_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
